// File: rtl/unidade_controle_jogo_seq.sv
// Moore sequencer for the memory game: grows the sequence per round,
// waits for each play with a timeout, and reports win / error / timeout.
module unidade_controle_jogo_seq #(
  parameter int TIMEOUT_CICLOS = 3000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  localparam int TW = $clog2(TIMEOUT_CICLOS);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CICLOS - 1);

  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARA    = 4'h1,
    ESPERA     = 4'h2,
    REGISTRA   = 4'h3,
    COMPARA    = 4'h4,
    PROXIMO    = 4'h5,
    PROX_SEQ   = 4'h6,
    FIM_GANHOU = 4'hA,
    FIM_TOUT   = 4'hD,
    FIM_ERRO   = 4'hE
  } estado_t;

  estado_t       estado;
  estado_t       prox;
  logic [TW-1:0] tmr;
  logic          tout;

  assign tout = (tmr == TMAX);

  // tmr only runs while waiting, so every entry to ESPERA gets a full window
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
      tmr    <= '0;
    end else begin
      estado <= prox;
      tmr    <= (estado == ESPERA) ? tmr + TW'(1) : '0;
    end
  end

  always_comb begin
    prox = INICIAL;
    case (estado)
      INICIAL:    prox = jogar ? PREPARA : INICIAL;
      PREPARA:    prox = ESPERA;
      ESPERA: begin
        if (jogada)    prox = REGISTRA;
        else if (tout) prox = FIM_TOUT;
        else           prox = ESPERA;
      end
      REGISTRA:   prox = COMPARA;
      COMPARA: begin
        if (!igual)     prox = FIM_ERRO;
        else if (!fimE) prox = PROXIMO;
        else if (fimL)  prox = FIM_GANHOU;
        else            prox = PROX_SEQ;
      end
      PROXIMO:    prox = ESPERA;
      PROX_SEQ:   prox = ESPERA;
      FIM_GANHOU: prox = jogar ? PREPARA : FIM_GANHOU;
      FIM_ERRO:   prox = jogar ? PREPARA : FIM_ERRO;
      FIM_TOUT:   prox = jogar ? PREPARA : FIM_TOUT;
      default:    prox = INICIAL;
    endcase
  end

  always_comb begin
    zeraE      = 1'b0;
    contaE     = 1'b0;
    zeraL      = 1'b0;
    contaL     = 1'b0;
    zeraR      = 1'b0;
    registraR  = 1'b0;
    pronto     = 1'b0;
    ganhou     = 1'b0;
    perdeu     = 1'b0;
    db_timeout = 1'b0;
    case (estado)
      PREPARA: begin
        zeraE = 1'b1;
        zeraL = 1'b1;
        zeraR = 1'b1;
      end
      REGISTRA: registraR = 1'b1;
      PROXIMO:  contaE = 1'b1;
      PROX_SEQ: begin
        contaL = 1'b1;
        zeraE  = 1'b1;
      end
      FIM_GANHOU: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      FIM_ERRO: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      FIM_TOUT: begin
        pronto     = 1'b1;
        perdeu     = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule
